pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipeline_hazard_ctrl_sat_counter16.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for hazard control: register-index width, FSM state codes, control bundle.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned REG_IDX_W = 3;
   localparam int unsigned STATE_W   = 2;
   localparam int unsigned CNT_W     = 16;

   localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
   localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [STATE_W-1:0] ST_FLUSH    = 2'd2;

   typedef struct packed {
      logic stall_pc;
      logic stall_pr1;
      logic stall_pr2;
      logic stall_pr3;
      logic flush_pr1;
      logic bubble_pr2;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE     = '{default: 1'b0};
   localparam ctrl_t CTRL_MEM_HOLD = '{stall_pc: 1'b1, stall_pr1: 1'b1, stall_pr2: 1'b1,
                                       stall_pr3: 1'b1, flush_pr1: 1'b0, bubble_pr2: 1'b0};
   localparam ctrl_t CTRL_FLUSH    = '{stall_pc: 1'b0, stall_pr1: 1'b0, stall_pr2: 1'b0,
                                       stall_pr3: 1'b0, flush_pr1: 1'b1, bubble_pr2: 1'b1};
   localparam ctrl_t CTRL_LOAD_USE = '{stall_pc: 1'b1, stall_pr1: 1'b1, stall_pr2: 1'b0,
                                       stall_pr3: 1'b0, flush_pr1: 1'b0, bubble_pr2: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter16
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (en && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bubble control for a 5-stage pipeline: load-use, memory wait and taken-branch
// handling with saturating stall and flush performance counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] ID_rs1,
   input  logic [REG_IDX_W-1:0] ID_rs2,
   input  logic                 ID_uses_rs1,
   input  logic                 ID_uses_rs2,
   input  logic                 PR2_MEM_read,
   input  logic                 PR2_RF_write_en,
   input  logic [REG_IDX_W-1:0] PR2_rd,
   input  logic                 EX_branch_taken,
   input  logic                 MEM_busy,
   output logic                 stall_PC,
   output logic                 stall_PR1,
   output logic                 stall_PR2,
   output logic                 stall_PR3,
   output logic                 flush_PR1,
   output logic                 bubble_PR2,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_count
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_next;
   logic               pending_flush;
   logic               pending_flush_next;
   logic               hz;
   ctrl_t              ctrl;

   // Load in EX whose destination feeds a source the ID instruction actually reads.
   assign hz = PR2_MEM_read & PR2_RF_write_en &
               ((ID_uses_rs1 & (ID_rs1 == PR2_rd)) | (ID_uses_rs2 & (ID_rs2 == PR2_rd)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_RUN;
         pending_flush <= 1'b0;
      end else begin
         state         <= state_next;
         pending_flush <= pending_flush_next;
      end
   end

   always_comb begin
      ctrl               = CTRL_IDLE;
      state_next         = state;
      pending_flush_next = pending_flush;
      if (!rst) begin
         case (state)
            ST_RUN: begin
               if (MEM_busy) begin
                  ctrl       = CTRL_MEM_HOLD;
                  state_next = ST_MEM_WAIT;
               end else if (EX_branch_taken) begin
                  ctrl       = CTRL_FLUSH;
                  state_next = ST_FLUSH;
               end else if (hz) begin
                  ctrl       = CTRL_LOAD_USE;
               end
            end
            ST_MEM_WAIT: begin
               if (MEM_busy) begin
                  ctrl = CTRL_MEM_HOLD;
                  if (EX_branch_taken) begin
                     pending_flush_next = 1'b1;
                  end
               end else if (pending_flush || EX_branch_taken) begin
                  ctrl               = CTRL_FLUSH;
                  pending_flush_next = 1'b0;
                  state_next         = ST_FLUSH;
               end else begin
                  if (hz) begin
                     ctrl = CTRL_LOAD_USE;
                  end
                  state_next = ST_RUN;
               end
            end
            ST_FLUSH: begin
               // ID holds a flushed NOP here, so a hazard match is meaningless.
               if (MEM_busy) begin
                  ctrl       = CTRL_MEM_HOLD;
                  state_next = ST_MEM_WAIT;
               end else if (EX_branch_taken) begin
                  ctrl       = CTRL_FLUSH;
               end else begin
                  state_next = ST_RUN;
               end
            end
            default: begin
               state_next = ST_RUN;
            end
         endcase
      end
   end

   assign stall_PC   = ctrl.stall_pc;
   assign stall_PR1  = ctrl.stall_pr1;
   assign stall_PR2  = ctrl.stall_pr2;
   assign stall_PR3  = ctrl.stall_pr3;
   assign flush_PR1  = ctrl.flush_pr1;
   assign bubble_PR2 = ctrl.bubble_pr2;

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .en    (ctrl.stall_pc),
      .count (stall_cycles)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .clear (rst),
      .en    (ctrl.flush_pr1),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic       u1;
      logic       u2;
      logic       mr;
      logic       we;
      logic [2:0] rd;
      logic       br;
      logic       busy;
   } stim_t;

   typedef struct packed {
      logic [5:0]  ctl;
      logic        chk_cnt;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  ID_rs1, ID_rs2, PR2_rd;
   logic        ID_uses_rs1, ID_uses_rs2, PR2_MEM_read, PR2_RF_write_en;
   logic        EX_branch_taken, MEM_busy;
   logic        stall_PC, stall_PR1, stall_PR2, stall_PR3, flush_PR1, bubble_PR2;
   logic [15:0] stall_cycles, flush_count;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: a stalled-by-memory flag, a just-flushed flag and a remembered branch.
   bit   m_waiting  = 1'b0;
   bit   m_flushed  = 1'b0;
   bit   m_pend     = 1'b0;
   bit   m_cnt_known = 1'b0;
   int   m_stalls   = 0;
   int   m_flushes  = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .ID_rs1          (ID_rs1),
      .ID_rs2          (ID_rs2),
      .ID_uses_rs1     (ID_uses_rs1),
      .ID_uses_rs2     (ID_uses_rs2),
      .PR2_MEM_read    (PR2_MEM_read),
      .PR2_RF_write_en (PR2_RF_write_en),
      .PR2_rd          (PR2_rd),
      .EX_branch_taken (EX_branch_taken),
      .MEM_busy        (MEM_busy),
      .stall_PC        (stall_PC),
      .stall_PR1       (stall_PR1),
      .stall_PR2       (stall_PR2),
      .stall_PR3       (stall_PR3),
      .flush_PR1       (flush_PR1),
      .bubble_PR2      (bubble_PR2),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   // Drive one cycle of inputs just after the edge and queue what the pipeline rules demand.
   task automatic apply(input stim_t s);
      bit   hazard;
      bit   hold_all, do_flush, load_use;
      exp_t e;
      @(posedge clk);
      #1;
      rst = s.rst; ID_rs1 = s.rs1; ID_rs2 = s.rs2; ID_uses_rs1 = s.u1; ID_uses_rs2 = s.u2;
      PR2_MEM_read = s.mr; PR2_RF_write_en = s.we; PR2_rd = s.rd;
      EX_branch_taken = s.br; MEM_busy = s.busy;

      hazard   = s.mr && s.we && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      hold_all = 1'b0; do_flush = 1'b0; load_use = 1'b0;
      if (s.rst) begin
         m_waiting = 1'b0; m_flushed = 1'b0; m_pend = 1'b0;
      end else if (s.busy) begin
         hold_all = 1'b1;
         if (m_waiting && s.br) m_pend = 1'b1;
         m_waiting = 1'b1; m_flushed = 1'b0;
      end else if (s.br || (m_waiting && m_pend)) begin
         do_flush = 1'b1;
         m_waiting = 1'b0; m_flushed = 1'b1; m_pend = 1'b0;
      end else begin
         load_use  = hazard && !m_flushed;
         m_waiting = 1'b0; m_flushed = 1'b0;
      end

      e.ctl     = {hold_all | load_use, hold_all | load_use, hold_all, hold_all,
                   do_flush, do_flush | load_use};
      e.chk_cnt = m_cnt_known;
      e.sc      = 16'(m_stalls);
      e.fc      = 16'(m_flushes);
      q.push_back(e);

      if (s.rst) begin
         m_stalls = 0; m_flushes = 0; m_cnt_known = 1'b1;
      end else begin
         if (hold_all || load_use) m_stalls = (m_stalls >= 65535) ? 65535 : m_stalls + 1;
         if (do_flush) m_flushes = (m_flushes >= 65535) ? 65535 : m_flushes + 1;
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic [5:0] act;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {stall_PC, stall_PR1, stall_PR2, stall_PR3, flush_PR1, bubble_PR2};
         n_checks++;
         if (act !== e.ctl) begin
            n_fail++;
            $display("FAIL ctrl t=%0t got=%b want=%b (PC,PR1,PR2,PR3,flush,bubble)", $time, act, e.ctl);
         end
         if (e.chk_cnt) begin
            n_checks++;
            if (stall_cycles !== e.sc) begin
               n_fail++;
               $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, stall_cycles, e.sc);
            end
            n_checks++;
            if (flush_count !== e.fc) begin
               n_fail++;
               $display("FAIL flush_count t=%0t got=%0d want=%0d", $time, flush_count, e.fc);
            end
         end
      end
   end

   initial begin
      stim_t s;
      int    guard;
      rst = 1'b1; ID_rs1 = '0; ID_rs2 = '0; PR2_rd = '0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
      PR2_MEM_read = 1'b0; PR2_RF_write_en = 1'b0; EX_branch_taken = 1'b0; MEM_busy = 1'b0;

      s = idle(); s.rst = 1'b1;
      apply(s); apply(s);
      apply(idle());

      // Load-use on rs2 == rd == 3, then quiet.
      s = idle(); s.mr = 1'b1; s.we = 1'b1; s.rd = 3'd3; s.rs2 = 3'd3; s.u2 = 1'b1;
      apply(s); apply(idle()); apply(idle());
      // Same registers but rs2 not read, then not a load.
      s.u2 = 1'b0; apply(s);
      s.u2 = 1'b1; s.mr = 1'b0; apply(s);
      // Register 0 matches like any other index.
      s = idle(); s.mr = 1'b1; s.we = 1'b1; s.rd = 3'd0; s.rs1 = 3'd0; s.u1 = 1'b1;
      apply(s); apply(idle());

      // Branch with hazard present, then hazard persists into the flush cycle.
      s = idle(); s.mr = 1'b1; s.we = 1'b1; s.rd = 3'd5; s.rs1 = 3'd5; s.u1 = 1'b1; s.br = 1'b1;
      apply(s);
      s.br = 1'b0; apply(s);
      apply(idle());

      // Four busy cycles with a branch in the second, released on the fifth.
      s = idle(); s.busy = 1'b1;
      apply(s);
      s.br = 1'b1; apply(s);
      s.br = 1'b0; apply(s); apply(s);
      apply(idle()); apply(idle()); apply(idle());

      // Reset in the middle of a memory wait that had a branch recorded.
      s = idle(); s.busy = 1'b1; s.br = 1'b1;
      apply(s); apply(s);
      s.rst = 1'b1; apply(s);
      s = idle(); apply(s); apply(s);

      // Back-to-back branches and a flush interrupted by memory.
      s = idle(); s.br = 1'b1; apply(s); apply(s);
      s.busy = 1'b1; apply(s);
      s.busy = 1'b0; s.br = 1'b0; apply(s); apply(idle());

      for (int i = 0; i < 3000; i++) begin
         s.rst  = ($urandom_range(0, 99) < 2);
         s.rs1  = 3'($urandom_range(0, 3));
         s.rs2  = 3'($urandom_range(0, 3));
         s.rd   = 3'($urandom_range(0, 3));
         s.u1   = $urandom_range(0, 1) == 1;
         s.u2   = $urandom_range(0, 1) == 1;
         s.mr   = ($urandom_range(0, 9) < 6);
         s.we   = ($urandom_range(0, 9) < 7);
         s.br   = ($urandom_range(0, 99) < 15);
         s.busy = ($urandom_range(0, 99) < 15);
         apply(s);
      end

      // Hold memory busy long enough to saturate the stall counter.
      s = idle(); s.rst = 1'b1; apply(s);
      s = idle(); s.busy = 1'b1;
      for (int i = 0; i < 70000; i++) apply(s);
      apply(idle()); apply(idle());

      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
